// File: rtl/ook_pkg.sv
// Shared types and default framing constants for the OOK symbol framer.
package ook_pkg;

  // Framer sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    DATA,
    GAP
  } state_t;

  // Default framing constants.
  localparam logic [7:0] SYNC_WORD_DEF    = 8'hD3;
  localparam int         PREAMBLE_LEN_DEF = 8;
  localparam int         GAP_SYMS_DEF     = 4;

  // Width of the per-phase symbol index.
  // It must hold PREAMBLE_LEN-1, GAP_SYMS-1 and 7.
  localparam int IDX_W = 8;

endpackage

// File: rtl/ook_symbol_timer.sv
// Symbol-rate timer.
// The divider is latched when a frame starts, so later baud_div changes do
// not alter the current frame. The tick is high on the last clock of each
// symbol; the count then wraps to 0, giving div_q+1 clocks per symbol.
module ook_symbol_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] div_in,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == div_q);

  // Latch the divider on frame start; otherwise count 0..div_q and wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (start) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      div_q <= div_in;
      cnt   <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ook_symbol_framer.sv
// OOK symbol framer.
// Each frame is sent as: alternating preamble, sync word, payload bytes
// MSB-first, then forced-zero gap symbols. The rf_data output is the keying
// bit for the DDS, and it changes only on symbol boundaries.
module ook_symbol_framer
  import ook_pkg::*;
#(
  parameter int         DIV_W        = 16,
  parameter int         PREAMBLE_LEN = PREAMBLE_LEN_DEF,
  parameter logic [7:0] SYNC_WORD    = SYNC_WORD_DEF,
  parameter int         GAP_SYMS     = GAP_SYMS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             rf_data,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);

  localparam logic [IDX_W-1:0] LAST_PRE = IDX_W'(PREAMBLE_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_GAP = IDX_W'(GAP_SYMS - 1);

  // Sequencer state and symbol index.
  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;

  // Holding register: one byte plus its last flag.
  logic       hold_full;
  logic [7:0] hold_data;
  logic       hold_last;

  // Shift register for the byte currently being sent.
  logic [7:0] shift_q, shift_d;
  logic       shift_last, shift_last_d;

  // Next-state values for the registered outputs.
  logic rf_d;
  logic frame_done_d;
  logic underrun_d;

  // Control strobes.
  logic load;
  logic timer_start;
  logic tick;

  assign s_ready = ~hold_full;
  assign busy    = (state != IDLE);

  ook_symbol_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (timer_start),
    .div_in (baud_div),
    .tick   (tick)
  );

  // Accept a byte when the register is empty; it empties when loaded for transmit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (s_valid && s_ready) begin
      hold_full <= 1'b1;
      hold_data <= s_data;
      hold_last <= s_last;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Symbol index, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      shift_q    <= '0;
      shift_last <= 1'b0;
      rf_data    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      idx        <= idx_d;
      shift_q    <= shift_d;
      shift_last <= shift_last_d;
      rf_data    <= rf_d;
      frame_done <= frame_done_d;
      underrun   <= underrun_d;
    end
  end

  // Next-state logic.
  // Outside IDLE, the sequencer moves only on a symbol tick.
  // rf_d is always the value of the next symbol.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d      = state;
    idx_d        = idx;
    shift_d      = shift_q;
    shift_last_d = shift_last;
    rf_d         = rf_data;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    load         = 1'b0;
    timer_start  = 1'b0;

    unique case (state)
      IDLE: begin
        rf_d = 1'b0;
        if (hold_full) begin
          state_d     = PREAMBLE;
          timer_start = 1'b1;
          idx_d       = '0;
          rf_d        = 1'b1;
        end
      end

      PREAMBLE: begin
        if (tick) begin
          if (idx == LAST_PRE) begin
            state_d = SYNC;
            idx_d   = '0;
            rf_d    = SYNC_WORD[7];
          end else begin
            // Next symbol idx+1 is 1 when idx+1 is even, i.e. when idx is odd.
            idx_d = idx + IDX_W'(1);
            rf_d  = idx[0];
          end
        end
      end

      SYNC: begin
        if (tick) begin
          if (idx[2:0] == 3'd7) begin
            state_d      = DATA;
            idx_d        = '0;
            load         = 1'b1;
            shift_d      = hold_data;
            shift_last_d = hold_last;
            rf_d         = hold_data[7];
          end else begin
            idx_d = idx + IDX_W'(1);
            rf_d  = SYNC_WORD[3'd6 - idx[2:0]];
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (idx[2:0] == 3'd7) begin
            idx_d = '0;
            if (shift_last) begin
              state_d = GAP;
              rf_d    = 1'b0;
            end else if (hold_full) begin
              // Chain straight into the next byte with no idle symbol.
              load         = 1'b1;
              shift_d      = hold_data;
              shift_last_d = hold_last;
              rf_d         = hold_data[7];
            end else begin
              underrun_d = 1'b1;
              state_d    = GAP;
              rf_d       = 1'b0;
            end
          end else begin
            idx_d   = idx + IDX_W'(1);
            shift_d = {shift_q[6:0], 1'b0};
            rf_d    = shift_q[6];
          end
        end
      end

      GAP: begin
        rf_d = 1'b0;
        if (tick) begin
          if (idx == LAST_GAP) begin
            state_d      = IDLE;
            idx_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        rf_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ook_symbol_framer.sv
// Directed self-checking bench for ook_symbol_framer.
// Every expected symbol stream below is hand-built from the frame format:
// preamble 10101010, sync 11010011, payload MSB-first, then gap 0000.
module tb_ook_symbol_framer;

  logic        clk;
  logic        rst;
  logic [15:0] baud_div;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        rf_data;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  ook_symbol_framer dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .rf_data    (rf_data),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one byte at a negedge. Check that it is accepted at the next edge,
  // then check that the frame starts on the edge after that.
  // The task returns at the negedge of symbol cycle 0.
  task automatic start_frame(input string tag, input logic [7:0] b, input logic last, input bit keep_valid);
    s_data  = b;
    s_last  = last;
    s_valid = 1'b1;
    @(negedge clk);
    check({tag, " accept s_ready"}, 32'(s_ready), 32'd0);
    check({tag, " accept busy"}, 32'(busy), 32'd0);
    if (!keep_valid) s_valid = 1'b0;
    @(negedge clk);
    check({tag, " start busy"}, 32'(busy), 32'd1);
  endtask

  // Walk a whole frame starting at cycle 0, checking every clock.
  // exp holds the symbols with the first symbol at bit nsyms-1.
  // Bit c of rdy_exp is the required s_ready in cycle c.
  task automatic run_frame(input string tag, input logic [127:0] exp, input int nsyms,
                           input int d, input int und_sym, input logic [127:0] rdy_exp,
                           input bit chk_rdy, input int drop_at);
    int cyc;
    for (int k = 0; k < nsyms; k++) begin
      for (int c = 0; c <= d; c++) begin
        cyc = k * (d + 1) + c;
        check({tag, " rf_data"}, 32'(rf_data), 32'(exp[nsyms-1-k]));
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " frame_done low"}, 32'(frame_done), 32'd0);
        check({tag, " underrun"}, 32'(underrun), 32'((k == und_sym) && (c == 0)));
        if (chk_rdy) check({tag, " s_ready"}, 32'(s_ready), 32'(rdy_exp[cyc]));
        if (cyc == drop_at) s_valid = 1'b0;
        @(negedge clk);
      end
    end
    check({tag, " frame_done pulse"}, 32'(frame_done), 32'd1);
    check({tag, " end busy"}, 32'(busy), 32'd0);
    check({tag, " end rf_data"}, 32'(rf_data), 32'd0);
    check({tag, " end underrun"}, 32'(underrun), 32'd0);
    @(negedge clk);
    check({tag, " frame_done one cycle"}, 32'(frame_done), 32'd0);
    check({tag, " idle s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    logic [7:0]  offer [3];
    logic [7:0]  sent_q [$];
    bit          cap_q [$];
    logic [7:0]  v;
    logic [15:0] hdr;
    int          n;
    bit          acc;
    bit          done;
    bit          seen_busy;
    bit          seen_done;
    bit          seen_und;

    rst      = 1'b0;
    baud_div = '0;
    s_data   = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;

    // Values held in reset.
    repeat (3) @(negedge clk);
    check("reset rf_data", 32'(rf_data), 32'd0);
    check("reset s_ready", 32'(s_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset underrun", 32'(underrun), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5, 4 clocks per symbol, 112 cycles to frame_done.
    // s_ready rises in cycle 64, after the load at the end of sync.
    baud_div = 16'd3;
    start_frame("single", 8'hA5, 1'b1, 1'b0);
    run_frame("single", 128'hAAD3A50, 28, 3, -1, ~(128'h0) << 64, 1'b1, -1);

    // Back-to-back 0x0F then 0xF0 (last), one clock per symbol.
    // s_ready is high in cycle 16 only while 0xF0 is offered, then from cycle 24.
    baud_div = 16'd0;
    start_frame("b2b", 8'h0F, 1'b0, 1'b1);
    s_data = 8'hF0;
    s_last = 1'b1;
    run_frame("b2b", 128'hAAD30FF00, 36, 0, -1, 128'hF_FF01_0000, 1'b1, 17);

    // Underrun: 0x3C without last and no follow-up byte.
    baud_div = 16'd1;
    start_frame("underrun", 8'h3C, 1'b0, 1'b0);
    run_frame("underrun", 128'hAAD33C0, 28, 1, 24, '0, 1'b0, -1);

    // Rate latch: divider raised to 7 mid-frame, so this frame stays at 2 clocks per symbol.
    baud_div = 16'd1;
    start_frame("rate1", 8'h5A, 1'b1, 1'b0);
    baud_div = 16'd7;
    run_frame("rate1", 128'hAAD35A0, 28, 1, -1, '0, 1'b0, -1);
    // The next frame picks up 8 clocks per symbol.
    start_frame("rate2", 8'hC3, 1'b1, 1'b0);
    run_frame("rate2", 128'hAAD3C30, 28, 7, -1, '0, 1'b0, -1);

    // Backpressure: s_valid stays high across three bytes, one clock per symbol.
    offer[0] = 8'h11;
    offer[1] = 8'h22;
    offer[2] = 8'h33;
    baud_div = 16'd0;
    n        = 0;
    done     = 1'b0;
    s_data   = offer[0];
    s_last   = 1'b0;
    s_valid  = 1'b1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      acc = s_valid && s_ready;
      if (busy) cap_q.push_back(rf_data);
      if (frame_done) done = 1'b1;
      @(negedge clk);
      if (acc) begin
        sent_q.push_back(s_data);
        n++;
        if (n < 3) begin
          s_data = offer[n];
          s_last = (n == 2);
        end else begin
          s_valid = 1'b0;
        end
      end
    end
    s_valid = 1'b0;
    check("bp frame_done seen", 32'(done), 32'd1);
    check("bp bytes accepted", 32'(sent_q.size()), 32'd3);
    check("bp symbol count", 32'(cap_q.size()), 32'd44);
    if (sent_q.size() == 3 && cap_q.size() == 44) begin
      hdr = '0;
      for (int j = 0; j < 16; j++) hdr = {hdr[14:0], cap_q[j]};
      check("bp header", 32'(hdr), 32'hAAD3);
      for (int b = 0; b < 3; b++) begin
        v = '0;
        for (int j = 0; j < 8; j++) v = {v[6:0], cap_q[16 + 8 * b + j]};
        check("bp scoreboard byte", 32'(v), 32'(sent_q[b]));
        check("bp accepted byte", 32'(sent_q[b]), 32'(offer[b]));
      end
    end
    repeat (2) @(negedge clk);

    // Mid-DATA reset with a second byte already held: the frame aborts with no
    // frame_done, and the held byte is dropped.
    baud_div = 16'd3;
    start_frame("abort", 8'h81, 1'b0, 1'b0);
    s_data  = 8'h7E;
    s_last  = 1'b1;
    s_valid = 1'b1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (cyc == 65) begin
        check("abort second byte taken", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("abort busy before reset", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort rf_data", 32'(rf_data), 32'd0);
    check("abort s_ready", 32'(s_ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    seen_busy = 1'b0;
    seen_done = 1'b0;
    seen_und  = 1'b0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
      if (frame_done) seen_done = 1'b1;
      if (underrun) seen_und = 1'b1;
    end
    check("post-abort no restart", 32'(seen_busy), 32'd0);
    check("post-abort no frame_done", 32'(seen_done), 32'd0);
    check("post-abort no underrun", 32'(seen_und), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ook_symbol_framer.md
Name: ook_symbol_framer

Overview:
- Upstream neighbour of the OOK/FSK DDS core: generates the serial rf_data keying stream that selects tone or silence.
- Accepts payload bytes over a valid/ready handshake and frames them as preamble, sync word, then payload MSB-first.
- Runs at a runtime-programmable symbol rate derived from clk; rf_data feeds the DDS rf_data input directly.

Parameters:
- DIV_W, 16, width of baud_div and the symbol counter
- PREAMBLE_LEN, 8, number of alternating preamble symbols, first symbol 1
- SYNC_WORD, 8'hD3, sync pattern sent MSB-first after the preamble
- GAP_SYMS, 4, number of forced-0 symbols after each frame

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- baud_div  in  DIV_W  clocks per symbol minus 1; sampled at frame start
- s_data  in  8  payload byte
- s_valid  in  1  s_data valid
- s_last  in  1  byte is the final byte of the frame; qualified by s_valid
- s_ready  out  1  holding register empty, so a byte can be accepted
- rf_data  out  1  keying bit to the DDS, registered
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse on the GAP to IDLE transition
- underrun  out  1  one-cycle pulse when a frame ends early because no byte was ready

Behaviour:
- Reset (rst low, asynchronous):
  - State is IDLE; holding register and shift register are empty.
  - rf_data=0, s_ready=1, busy=0, frame_done=0, underrun=0.
- Holding register:
  - One byte plus its last flag.
  - A byte is accepted on a clk edge where s_valid && s_ready; s_ready drops the next cycle.
  - The register empties when its byte is loaded into the shift register, and s_ready rises the next cycle.
  - If a load and an accept fall on the same edge, the load wins and the accept is ignored, because s_ready was already low.
- Symbol timer:
  - Counter runs 0..div_q, where div_q is baud_div latched on IDLE exit.
  - A tick occurs on the cycle where the count equals div_q; the counter then wraps to 0.
  - Each symbol is held div_q+1 cycles.
  - baud_div=0 gives one symbol per clock.
  - Changes to baud_div mid-frame have no effect.
- State machine (advances only on a tick, except on IDLE exit):
  - IDLE:
    - Holds rf_data=0.
    - When the holding register is full, the next edge enters PREAMBLE: latches div_q, clears the counter, drives rf_data=1, and sets the symbol index to 0.
  - PREAMBLE:
    - Symbol i is 1 for even i and 0 for odd i.
    - After PREAMBLE_LEN symbols, enter SYNC.
  - SYNC:
    - Sends the 8 bits of SYNC_WORD MSB-first.
    - On the tick ending the last sync bit, loads the shift register from the holding register and enters DATA.
  - DATA:
    - Sends the shift register MSB-first, 8 symbols per byte.
    - On the tick ending bit 0 of a byte:
      - If the byte was flagged last, enter GAP.
      - Else if the holding register is full, load it and stay in DATA with no idle symbol inserted.
      - Else pulse underrun and enter GAP.
  - GAP:
    - rf_data=0 for GAP_SYMS symbols, then IDLE; frame_done pulses on that transition.
- A new frame may start on the cycle after IDLE is entered, if the holding register is full.
- rf_data changes only on a tick edge or on the IDLE exit edge, so it is glitch-free.
- Reset asserted mid-frame aborts immediately:
  - No frame_done is produced.
  - A held byte is discarded.
- Frame length for N bytes is (PREAMBLE_LEN + 8 + 8N + GAP_SYMS) × (div_q+1) cycles, measured from IDLE exit to frame_done.

Decomposition:
- Shared package ook_pkg:
  - State enum: IDLE, PREAMBLE, SYNC, DATA, GAP.
  - Defaults for SYNC_WORD, PREAMBLE_LEN, GAP_SYMS.
  - Symbol-index width constant.
- One sub-module: ook_symbol_timer.
  - Inputs: clk, rst, start, div_in.
  - Outputs: tick.
  - Latches div_in on start and clears the count.
- The FSM, holding register and shift register stay in the top module.

Test Plan:
- Reset values: pulse rst low mid-DATA with baud_div=3 -> rf_data=0, s_ready=1, busy=0 within the reset cycle; no frame_done pulse.
- Single byte: baud_div=3, send 0xA5 with s_last=1 -> rf_data sequence is 10101010 then 11010011 then 10100101 then 0000, each symbol held 4 cycles; frame_done pulses 112 cycles after IDLE exit.
- Back-to-back bytes: baud_div=0, send 0x0F, then 0xF0 with last, with s_valid held high -> data symbols 00001111 11110000 with no gap between bytes; s_ready rises one cycle after each load; frame_done after 36 cycles.
- Underrun: send 0x3C without s_last and no second byte -> 0x3C sent, underrun pulses once on the tick ending bit 0, then GAP, then frame_done.
- Backpressure: hold s_valid=1 for 3 bytes while the holding register is full -> each byte is accepted exactly once, only when s_ready=1; no byte is lost or duplicated, checked against a scoreboard.
- Rate latch: start a frame with baud_div=1, change it to 7 mid-frame -> all symbols of that frame last 2 cycles; the next frame uses 8 cycles per symbol.
